app_sequencer: RTL and testbench

Registered controller that owns the shared OLED, 7-segment and LED resources and decides which application holds them: menu, peak detector, pong, wave, tetris or passcode. It takes the debounced button pulses, the mic trigger, the menu selection and the passcode result, then drives the state code consumed by the final output mux. It also drives one-hot per-app enables. Every handover is separated by a blanking interval measured in OLED frames, so no app's pixels tear into another's.

---
 rtl/app_sequencer.sv | 162 ++++++++++++++++
 tb/tb_app_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/app_sequencer.sv
// app_sequencer: arbitrates the shared OLED / 7-segment / LED resources
// between the menu and the applications, with a frame-counted blanking
// interval on every handover.
// Optional feature macro: PASSCODE_LOCK_EN (tetris is gated behind passcode).
module app_sequencer #(
   parameter int unsigned BLANK_FRAMES = 8,
   parameter int unsigned MIC_HOLD     = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_sel,
   input  logic       btn_back,
   input  logic [2:0] menu_flag,
   input  logic       mic_trig,
   input  logic       pw_flag,
   input  logic       frame_tick,
   output logic [2:0] state,
   output logic [5:0] app_en,
   output logic       blank
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned EN_W    = 6;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned CMP_W   = CNT_W + 1;

   localparam logic [STATE_W-1:0] APP_MENU   = STATE_W'(0);
   localparam logic [STATE_W-1:0] APP_TETRIS = STATE_W'(4);
   localparam logic [STATE_W-1:0] APP_PASS   = STATE_W'(5);

   typedef enum logic [1:0] {
      FSM_MENU  = 2'd0,
      FSM_BLANK = 2'd1,
      FSM_RUN   = 2'd2
   } fsm_e;

   fsm_e               fsm_q, fsm_d;
   logic [STATE_W-1:0] tgt_q, tgt_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]   mic_cnt_q, mic_cnt_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [EN_W-1:0]    app_en_q, app_en_d;
   logic               blank_q, blank_d;

   logic               mic_hit_c;
   logic               sel_valid_c;
   logic               frame_done_c;
   logic [STATE_W-1:0] sel_tgt_c;

`ifdef PASSCODE_LOCK_EN
   logic unlocked_q, unlocked_d;
   // Tetris is redirected to the passcode screen until unlocked.
   assign sel_tgt_c = (menu_flag == APP_TETRIS && !unlocked_q) ? APP_PASS : menu_flag;
`else
   logic unused_pw_flag;
   assign unused_pw_flag = pw_flag;
   assign sel_tgt_c      = menu_flag;
`endif

   // Mic held high long enough counts as a select this cycle.
   assign mic_hit_c    = mic_trig && (CMP_W'(mic_cnt_q) + CMP_W'(1) == CMP_W'(MIC_HOLD));
   assign sel_valid_c  = (btn_sel || mic_hit_c) && (menu_flag != 3'd0) && (menu_flag <= 3'd4);
   assign frame_done_c = frame_tick && (CMP_W'(frame_cnt_q) + CMP_W'(1) == CMP_W'(BLANK_FRAMES));

   // State register: FSM, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q       <= FSM_MENU;
         tgt_q       <= '0;
         frame_cnt_q <= '0;
         mic_cnt_q   <= '0;
         state_q     <= '0;
         app_en_q    <= EN_W'(1);
         blank_q     <= 1'b0;
`ifdef PASSCODE_LOCK_EN
         unlocked_q  <= 1'b0;
`endif
      end else begin
         fsm_q       <= fsm_d;
         tgt_q       <= tgt_d;
         frame_cnt_q <= frame_cnt_d;
         mic_cnt_q   <= mic_cnt_d;
         state_q     <= state_d;
         app_en_q    <= app_en_d;
         blank_q     <= blank_d;
`ifdef PASSCODE_LOCK_EN
         unlocked_q  <= unlocked_d;
`endif
      end
   end

   // Next-state logic: selection, blanking countdown and return to menu.
   always_comb begin
      fsm_d       = fsm_q;
      tgt_d       = tgt_q;
      frame_cnt_d = frame_cnt_q;
      mic_cnt_d   = '0;
`ifdef PASSCODE_LOCK_EN
      unlocked_d  = unlocked_q;
`endif
      unique case (fsm_q)
         FSM_MENU: begin
            if (mic_trig && !mic_hit_c) begin
               mic_cnt_d = mic_cnt_q + CNT_W'(1);
            end
            if (sel_valid_c) begin
               tgt_d       = sel_tgt_c;
               frame_cnt_d = '0;
               mic_cnt_d   = '0;
               fsm_d       = FSM_BLANK;
            end
         end
         FSM_BLANK: begin
            if (frame_done_c) begin
               frame_cnt_d = '0;
               fsm_d       = (tgt_q == APP_MENU) ? FSM_MENU : FSM_RUN;
            end else if (frame_tick) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
         end
         FSM_RUN: begin
            if (btn_back) begin
               tgt_d       = APP_MENU;
               frame_cnt_d = '0;
               fsm_d       = FSM_BLANK;
`ifdef PASSCODE_LOCK_EN
               if (state_q == APP_TETRIS) begin
                  unlocked_d = 1'b0;
               end
            end else if (state_q == APP_PASS && pw_flag) begin
               unlocked_d  = 1'b1;
               tgt_d       = APP_TETRIS;
               frame_cnt_d = '0;
               fsm_d       = FSM_BLANK;
`endif
            end
         end
         default: fsm_d = FSM_MENU;
      endcase
   end

   // Output logic: derived from the next state so outputs track the FSM edge.
   always_comb begin
      state_d  = state_q;
      blank_d  = 1'b0;
      app_en_d = '0;
      unique case (fsm_d)
         FSM_MENU:  state_d = APP_MENU;
         FSM_RUN:   state_d = tgt_d;
         FSM_BLANK: blank_d = 1'b1;
         default:   state_d = APP_MENU;
      endcase
      if (!blank_d) begin
         app_en_d = EN_W'(1) << state_d;
      end
   end

   assign state  = state_q;
   assign app_en = app_en_q;
   assign blank  = blank_q;

endmodule

// File: tb/tb_app_sequencer.sv
// Bench for app_sequencer: table vectors, corner sequences and random
// stimulus against a behavioural model of the application handover rules.
module tb_app_sequencer;

   localparam int unsigned BF = 8;
   localparam int unsigned MH = 25;
`ifdef PASSCODE_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_sel = 1'b0, btn_back = 1'b0, mic_trig = 1'b0, pw_flag = 1'b0, frame_tick = 1'b0;
   logic [2:0] menu_flag = 3'd0;
   logic [2:0] state;
   logic [5:0] app_en;
   logic       blank;

   int checks = 0;
   int errors = 0;

   app_sequencer #(.BLANK_FRAMES(BF), .MIC_HOLD(MH)) dut (
      .clk(clk), .reset(reset), .btn_sel(btn_sel), .btn_back(btn_back),
      .menu_flag(menu_flag), .mic_trig(mic_trig), .pw_flag(pw_flag),
      .frame_tick(frame_tick), .state(state), .app_en(app_en), .blank(blank)
   );

   always #5 clk = ~clk;

   // Behavioural model: which app owns the screen, and how long it stays dark.
   int m_app, m_target, m_frames_left, m_mic_run;
   bit m_blanking, m_unlocked;

   task automatic model_step(input bit sel, input bit back, input int flag, input bit mic,
                             input bit pw, input bit frm, input bit rst);
      bit hit;
      if (rst) begin
         m_app = 0; m_target = 0; m_frames_left = 0; m_mic_run = 0;
         m_blanking = 0; m_unlocked = 0;
         return;
      end
      if (m_blanking) begin
         if (frm) begin
            m_frames_left--;
            if (m_frames_left == 0) begin
               m_blanking = 0;
               m_app = m_target;
            end
         end
      end else if (m_app == 0) begin
         m_mic_run = mic ? m_mic_run + 1 : 0;
         hit = (m_mic_run == MH);
         if (hit) m_mic_run = 0;
         if ((sel || hit) && flag >= 1 && flag <= 4) begin
            m_target = (LOCK && flag == 4 && !m_unlocked) ? 5 : flag;
            m_blanking = 1; m_frames_left = BF; m_mic_run = 0;
         end
      end else begin
         if (back) begin
            if (m_app == 4) m_unlocked = 0;
            m_target = 0; m_blanking = 1; m_frames_left = BF;
         end else if (LOCK && m_app == 5 && pw) begin
            m_unlocked = 1; m_target = 4; m_blanking = 1; m_frames_left = BF;
         end
      end
   endtask

   function automatic logic [5:0] exp_en();
      return m_blanking ? 6'd0 : 6'(1 << m_app);
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic cycle(input bit sel, input bit back, input int flag, input bit mic,
                        input bit pw, input bit frm, input bit rst);
      btn_sel = sel; btn_back = back; menu_flag = 3'(flag); mic_trig = mic;
      pw_flag = pw; frame_tick = frm; reset = rst;
      @(posedge clk);
      model_step(sel, back, flag, mic, pw, frm, rst);
      #1;
      check("model_state", int'(state), m_app);
      check("model_blank", int'(blank), int'(m_blanking));
      check("model_app_en", int'(app_en), int'(exp_en()));
   endtask

   task automatic idle(); cycle(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1, 0);
   endtask

   typedef struct {
      bit sel, back, mic, pw, frm, rst;
      int flag;
      int e_state, e_blank, e_en;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input bit sel, input bit back, input int flag, input bit frm,
                      input bit rst, input int es, input int eb, input int een);
      vec_t v;
      v.sel = sel; v.back = back; v.flag = flag; v.mic = 0; v.pw = 0;
      v.frm = frm; v.rst = rst; v.e_state = es; v.e_blank = eb; v.e_en = een;
      vecs.push_back(v);
   endtask

   bit mic_lvl;

   initial begin
      // Table: reset, select pong, blank 8 frames, back, blank 8 frames.
      add(0, 0, 0, 0, 1, 0, 0, 6'b000001);
      add(0, 0, 2, 0, 0, 0, 0, 6'b000001);
      add(1, 0, 2, 1, 0, 0, 1, 0);           // tick on entry is not counted
      for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 2, 0, 6'b000100);
      add(1, 0, 3, 0, 0, 2, 0, 6'b000100);   // select ignored in RUN
      add(0, 1, 0, 1, 0, 2, 1, 0);
      for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 6'b000001);
      add(1, 0, 6, 0, 0, 0, 0, 6'b000001);   // invalid menu_flag
      add(0, 1, 0, 0, 0, 0, 0, 6'b000001);   // back ignored in MENU

      foreach (vecs[i]) begin
         cycle(vecs[i].sel, vecs[i].back, vecs[i].flag, vecs[i].mic,
               vecs[i].pw, vecs[i].frm, vecs[i].rst);
         check($sformatf("vec%0d_state", i), int'(state), vecs[i].e_state);
         check($sformatf("vec%0d_blank", i), int'(blank), vecs[i].e_blank);
         check($sformatf("vec%0d_app_en", i), int'(app_en), vecs[i].e_en);
      end

      // Mic: 24 cycles high is not enough.
      for (int i = 0; i < MH - 1; i++) cycle(0, 0, 3, 1, 0, 0, 0);
      idle();
      check("mic24_blank", int'(blank), 0);
      // Mic: 25 cycles high selects wave, with a coincident btn_sel giving one select.
      for (int i = 0; i < MH - 1; i++) cycle(0, 0, 3, 1, 0, 0, 0);
      check("mic24b_blank", int'(blank), 0);
      cycle(1, 0, 3, 1, 0, 0, 0);
      check("mic25_blank", int'(blank), 1);
      check("mic25_en", int'(app_en), 0);
      frames(BF);
      check("mic_state", int'(state), 3);
      check("mic_en", int'(app_en), 6'b001000);
      cycle(0, 1, 0, 0, 0, 0, 0);
      frames(BF);
      check("mic_back_state", int'(state), 0);

`ifdef PASSCODE_LOCK_EN
      cycle(1, 0, 4, 0, 0, 0, 0); frames(BF);
      check("lock_pass_state", int'(state), 5);
      cycle(0, 0, 0, 0, 1, 0, 0);
      check("lock_pw_blank", int'(blank), 1);
      frames(BF);
      check("lock_tetris_state", int'(state), 4);
      check("lock_tetris_en", int'(app_en), 6'b010000);
      cycle(0, 1, 0, 0, 0, 0, 0); frames(BF);
      cycle(1, 0, 4, 0, 0, 0, 0); frames(BF);
      check("relock_state", int'(state), 5);
      cycle(0, 1, 0, 0, 1, 0, 0); frames(BF);
      check("backpw_state", int'(state), 0);
      cycle(1, 0, 4, 0, 0, 0, 0); frames(BF);
      check("backpw_still_locked", int'(state), 5);
      cycle(0, 1, 0, 0, 0, 0, 0); frames(BF);
`else
      cycle(1, 0, 4, 0, 0, 0, 0); frames(BF);
      check("direct_tetris_state", int'(state), 4);
      check("direct_tetris_en", int'(app_en), 6'b010000);
      cycle(0, 0, 0, 0, 1, 0, 0);
      check("pw_ignored_blank", int'(blank), 0);
      cycle(0, 1, 0, 0, 0, 0, 0); frames(BF);
      cycle(1, 0, 5, 0, 0, 0, 0);
      check("flag5_ignored", int'(blank), 0);
`endif

      // Reset at frame 4 of a blank, then a full blank afterwards.
      cycle(1, 0, 1, 0, 0, 0, 0); frames(4);
      cycle(0, 0, 0, 0, 0, 1, 1);
      check("rst_state", int'(state), 0);
      check("rst_blank", int'(blank), 0);
      check("rst_en", int'(app_en), 6'b000001);
      cycle(1, 0, 1, 0, 0, 0, 0); frames(BF - 1);
      check("rst_full_blank", int'(blank), 1);
      frames(1);
      check("rst_after_state", int'(state), 1);
      cycle(0, 1, 0, 0, 0, 0, 0); frames(BF);

      // Random stimulus against the model.
      mic_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) mic_lvl = ~mic_lvl;
         cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
               int'($urandom_range(0, 7)), mic_lvl, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
